borrowlookahead_serial_sub: RTL and testbench

Multi-cycle unsigned subtractor: computes D = X − Y − bin on W-bit operands, four bits per clock, LSB nibble first. A single 4-bit borrow-lookahead slice is reused each cycle, with the borrow carried between cycles in a register. It is the subtraction counterpart of the team's 4-bit carry-lookahead adder and sits beside it in the lab datapath. A valid/ready handshake on both sides lets a controller or bench stream operand pairs through it.

---
 rtl/sub_pkg.sv | 10 +
 rtl/borrowlookahead_4.sv | 26 ++
 rtl/borrowlookahead_serial_sub.sv | 109 ++++++++++
 tb/tb_borrowlookahead_serial_sub.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared definitions for the nibble-serial borrow-lookahead subtractor.
package sub_pkg;
   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sub_state_t;
endpackage

// File: rtl/borrowlookahead_4.sv
// Combinational 4-bit borrow-lookahead subtract slice: diff = a - b - bi.
module borrowlookahead_4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       bi,
   output logic [3:0] diff,
   output logic       bo
);
   logic [3:0] g, p;
   logic [4:0] br;

   assign g = ~a & b;
   assign p = ~(a ^ b);

   // All borrows expanded to two-level form so none waits on its neighbour.
   assign br[0] = bi;
   assign br[1] = g[0] | (p[0] & bi);
   assign br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
   assign br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & bi);
   assign br[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & bi);

   assign diff = a ^ b ^ br[3:0];
   assign bo   = br[4];
endmodule

// File: rtl/borrowlookahead_serial_sub.sv
// Nibble-serial subtractor D = X - Y - bin, one borrow-lookahead slice reused
// LSB nibble first. Define SUB_OVF_FLAG_EN to add the signed-overflow flag ovf.
module borrowlookahead_serial_sub
   import sub_pkg::*;
#(
   parameter  int NIBBLES = 4,
   localparam int W       = NIBBLE_W * NIBBLES
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic         bin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] d,
`ifdef SUB_OVF_FLAG_EN
   output logic         ovf,
`endif
   output logic         bout
);
   localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   sub_state_t state, state_nxt;
   logic [W-1:0]  xs, ys, res, next_res;
   logic [W+3:0]  res_cat;
   logic [CW-1:0] cnt;
   logic          br, last;
   logic [3:0]    slice_diff;
   logic          slice_bo;

   borrowlookahead_4 u_slice (
      .a    (xs[3:0]),
      .b    (ys[3:0]),
      .bi   (br),
      .diff (slice_diff),
      .bo   (slice_bo)
   );

   // New nibble enters at the MSB end; after NIBBLES shifts it is LSB-aligned.
   assign res_cat  = {slice_diff, res};
   assign next_res = res_cat[W+3:NIBBLE_W];
   assign last     = (cnt == CW'(NIBBLES - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = RUN;
         end
         RUN:  if (last) state_nxt = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         xs   <= '0;
         ys   <= '0;
         res  <= '0;
         cnt  <= '0;
         br   <= 1'b0;
         d    <= '0;
         bout <= 1'b0;
`ifdef SUB_OVF_FLAG_EN
         ovf  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               xs  <= x;
               ys  <= y;
               br  <= bin;
               cnt <= '0;
            end
            RUN: begin
               xs  <= xs >> NIBBLE_W;
               ys  <= ys >> NIBBLE_W;
               res <= next_res;
               br  <= slice_bo;
               cnt <= cnt + 1'b1;
               if (last) begin
                  d    <= next_res;
                  bout <= slice_bo;
`ifdef SUB_OVF_FLAG_EN
                  // On the last edge the slice holds the top nibble, so bit 3 is the sign.
                  ovf  <= (xs[3] ^ ys[3]) & (slice_diff[3] ^ xs[3]);
`endif
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_borrowlookahead_serial_sub.sv
// Self-checking bench: directed vector table, handshake corner sequences and
// random operands checked against an arithmetic reference model.
module tb_borrowlookahead_serial_sub;
   localparam int NIB = 4;
   localparam int W   = 4 * NIB;

   logic         clk = 1'b0;
   logic         rst_n, in_valid, in_ready, out_valid, out_ready, bin, bout, ovf;
   logic [W-1:0] x, y, d;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   borrowlookahead_serial_sub #(.NIBBLES(NIB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .d         (d),
`ifdef SUB_OVF_FLAG_EN
      .ovf       (ovf),
`endif
      .bout      (bout)
   );
`ifndef SUB_OVF_FLAG_EN
   assign ovf = 1'b0;
`endif

   typedef struct {
      logic [W-1:0] x, y;
      logic         bin;
      logic [W-1:0] exp_d;
      logic         exp_bout;
      logic         exp_ovf;
   } vec_t;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Reference: plain wide arithmetic.
   function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      vec_t v;
      logic [W:0] full;
      full       = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, c};
      v.x        = a;
      v.y        = b;
      v.bin      = c;
      v.exp_d    = full[W-1:0];
      v.exp_bout = ({1'b0, a} < ({1'b0, b} + {{W{1'b0}}, c}));
      v.exp_ovf  = (a[W-1] != b[W-1]) && (v.exp_d[W-1] != a[W-1]);
      return v;
   endfunction

   // Offer one operand pair, wait for the result, optionally consume it.
   task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_before_accept", {{(W-1){1'b0}}, in_ready}, 1);
      x = a; y = b; bin = c; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      x = W'($urandom); y = W'($urandom); bin = 1'($urandom);
   endtask

   task automatic wait_result(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!out_valid && lat < 100);
   endtask

   task automatic consume;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic run_vec(input string name, input vec_t v);
      int lat;
      start(v.x, v.y, v.bin);
      wait_result(lat);
      chk({name, "_lat"}, W'(lat), W'(NIB));
      chk({name, "_d"}, d, v.exp_d);
      chk({name, "_bout"}, {{(W-1){1'b0}}, bout}, {{(W-1){1'b0}}, v.exp_bout});
`ifdef SUB_OVF_FLAG_EN
      chk({name, "_ovf"}, {{(W-1){1'b0}}, ovf}, {{(W-1){1'b0}}, v.exp_ovf});
`endif
      consume();
   endtask

   vec_t tbl[6];

   initial begin
      logic [W-1:0] hd;
      logic         hb;
      int           lat;

      tbl[0] = '{16'h0005, 16'h0000, 1'b0, 16'h0005, 1'b0, 1'b0};
      tbl[1] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      tbl[2] = '{16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0};
      tbl[3] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0};
      tbl[4] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
      tbl[5] = '{16'h0001, 16'h0002, 1'b0, 16'hFFFF, 1'b1, 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0; bin = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", {{(W-1){1'b0}}, in_ready}, 1);
      chk("rst_out_valid", {{(W-1){1'b0}}, out_valid}, 0);
      chk("rst_d", d, 0);
      chk("rst_bout", {{(W-1){1'b0}}, bout}, 0);
      chk("rst_ovf", {{(W-1){1'b0}}, ovf}, 0);

      for (int i = 0; i < 6; i++) run_vec($sformatf("tbl%0d", i), tbl[i]);

      for (int i = 0; i < 15; i++)
         run_vec($sformatf("sweep%0d", i), model(W'(i), '0, 1'b1));

      // Backpressure: result must hold while new operands are waved at the input.
      start(16'h4321, 16'h1111, 1'b0);
      wait_result(lat);
      hd = d; hb = bout;
      chk("bp_d", hd, 16'h3210);
      for (int c = 0; c < 3; c++) begin
         in_valid = 1'($urandom); x = W'($urandom); y = W'($urandom); bin = 1'($urandom);
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("bp_valid%0d", c), {{(W-1){1'b0}}, out_valid}, 1);
         chk($sformatf("bp_ready%0d", c), {{(W-1){1'b0}}, in_ready}, 0);
         chk($sformatf("bp_hold_d%0d", c), d, hd);
         chk($sformatf("bp_hold_b%0d", c), {{(W-1){1'b0}}, bout}, {{(W-1){1'b0}}, hb});
      end
      in_valid = 1'b0;
      consume();
      @(negedge clk);
      chk("bp_idle_valid", {{(W-1){1'b0}}, out_valid}, 0);
      chk("bp_idle_d_kept", d, hd);

      // Abort mid-run with reset.
      start(16'hABCD, 16'h0123, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("abort_in_ready", {{(W-1){1'b0}}, in_ready}, 1);
      chk("abort_out_valid", {{(W-1){1'b0}}, out_valid}, 0);
      chk("abort_d", d, 0);
      run_vec("post_abort", model(16'h00FF, 16'h000F, 1'b0));

      for (int i = 0; i < 40; i++)
         run_vec($sformatf("rnd%0d", i), model(W'($urandom), W'($urandom), 1'($urandom)));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
